// File: rtl/updown_count_arbiter.sv
// rtl/updown_count_arbiter.sv - two-requester round-robin arbiter driving a shared up/down step counter
// Optional clamp-at-limits behaviour with sticky sat flag: define UPDOWN_COUNT_SAT_EN.
module updown_count_arbiter #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_dir,
    input  logic [STEP_W-1:0] req0_steps,
    input  logic              req1_valid,
    input  logic              req1_dir,
    input  logic [STEP_W-1:0] req1_steps,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              owner,
    output logic              done,
    output logic              sat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    state_t             state_q;
    logic [WIDTH-1:0]   count_q;
    logic [STEP_W-1:0]  rem_q;
    logic               dir_q;
    logic               owner_q;
    logic               rr_q;
    logic               done_q;
    logic               busy_q;

    logic               sel;
    logic               any_valid;
    logic               sel_dir;
    logic [STEP_W-1:0]  sel_steps;
    logic [WIDTH-1:0]   count_step;

    // Contention goes to the rr pointer; a lone requester always wins.
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        sel        = (req0_valid & req1_valid) ? rr_q : req1_valid;
        sel_dir    = sel ? req1_dir : req0_dir;
        sel_steps  = sel ? req1_steps : req0_steps;
        req0_ready = (state_q == IDLE) & any_valid & ~sel;
        req1_ready = (state_q == IDLE) & any_valid & sel;
        count_step = dir_q ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
    end

`ifdef UPDOWN_COUNT_SAT_EN
    logic sat_q;
    logic at_limit;
    assign at_limit = dir_q ? (count_q == '1) : (count_q == '0);
    assign sat      = sat_q;
`else
    assign sat      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UPDOWN_COUNT_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_ready | req1_ready) begin
                        owner_q <= sel;
                        dir_q   <= sel_dir;
                        rem_q   <= sel_steps;
                        busy_q  <= 1'b1;
                        if (sel_steps == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_q - STEP_ONE;
`ifdef UPDOWN_COUNT_SAT_EN
                    // Clamped steps still consume a step so latency matches wrap mode.
                    if (at_limit) begin
                        sat_q <= 1'b1;
                    end else begin
                        count_q <= count_step;
                    end
`else
                    count_q <= count_step;
`endif
                    if (rem_q == STEP_ONE) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    rr_q    <= ~owner_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign owner = owner_q;
    assign done  = done_q;

endmodule

// File: tb/tb_updown_count_arbiter.sv
// tb/tb_updown_count_arbiter.sv - directed self-checking bench for updown_count_arbiter
module tb_updown_count_arbiter;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_dir, req1_valid, req1_dir;
    logic [STEP_W-1:0] req0_steps, req1_steps;
    logic              req0_ready, req1_ready;
    logic [WIDTH-1:0]  count;
    logic              busy, owner, done, sat;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef UPDOWN_COUNT_SAT_EN
    localparam int EXP_DOWN3 = 0;
    localparam int EXP_WRAP  = 15;
    localparam int EXP_SAT   = 1;
`else
    localparam int EXP_DOWN3 = 13;
    localparam int EXP_WRAP  = 1;
    localparam int EXP_SAT   = 0;
`endif

    updown_count_arbiter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_dir   (req0_dir),
        .req0_steps (req0_steps),
        .req1_valid (req1_valid),
        .req1_dir   (req1_dir),
        .req1_steps (req1_steps),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .count      (count),
        .busy       (busy),
        .owner      (owner),
        .done       (done),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_done(input int limit, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < limit);
    endtask

    task automatic drive0(input logic v, input logic d, input int s);
        req0_valid = v;
        req0_dir   = d;
        req0_steps = STEP_W'(s);
        #1;
    endtask

    task automatic drive1(input logic v, input logic d, input int s);
        req1_valid = v;
        req1_dir   = d;
        req1_steps = STEP_W'(s);
        #1;
    endtask

    initial begin
        int lat;
        logic seen_done;
        rst = 1'b1;
        drive0(1'b0, 1'b0, 0);
        drive1(1'b0, 1'b0, 0);
        tick();
        tick();
        check_eq("rst_count", count, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_owner", owner, 0);
        check_eq("rst_sat", sat, 0);

        // Five-step up command from requester 0
        rst = 1'b0;
        drive0(1'b1, 1'b1, 5);
        check_eq("up5_ready0", req0_ready, 1);
        check_eq("up5_ready1", req1_ready, 0);
        tick();
        drive0(1'b0, 1'b0, 0);
        check_eq("up5_busy", busy, 1);
        check_eq("up5_noready", req0_ready, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq($sformatf("up5_count%0d", i), count, i);
            check_eq($sformatf("up5_done%0d", i), done, (i == 5) ? 1 : 0);
        end
        check_eq("up5_owner", owner, 0);
        tick();
        check_eq("up5_done_clr", done, 0);
        check_eq("up5_idle", busy, 0);

        // Down through zero from requester 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive1(1'b1, 1'b0, 3);
        check_eq("dn3_ready1", req1_ready, 1);
        tick();
        drive1(1'b0, 1'b0, 0);
        run_to_done(40, lat);
        check_eq("dn3_lat", lat, 3);
        check_eq("dn3_count", count, EXP_DOWN3);
        check_eq("dn3_sat", sat, EXP_SAT);
        check_eq("dn3_owner", owner, 1);
        tick();

        // Contention: rr pointer starts at 0, then alternates
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rr_sat_clr", sat, 0);
        drive0(1'b1, 1'b1, 2);
        drive1(1'b1, 1'b1, 2);
        check_eq("rr_first_r0", req0_ready, 1);
        check_eq("rr_first_r1", req1_ready, 0);
        tick();
        check_eq("rr_run_noready", {req0_ready, req1_ready}, 0);
        run_to_done(40, lat);
        check_eq("rr_a_count", count, 2);
        check_eq("rr_a_owner", owner, 0);
        tick();
        check_eq("rr_second_r0", req0_ready, 0);
        check_eq("rr_second_r1", req1_ready, 1);
        tick();
        drive0(1'b0, 1'b0, 0);
        drive1(1'b0, 1'b0, 0);
        run_to_done(40, lat);
        check_eq("rr_b_lat", lat, 2);
        check_eq("rr_b_count", count, 4);
        check_eq("rr_b_owner", owner, 1);
        tick();

        // Zero-step command goes straight to DONE
        drive0(1'b1, 1'b1, 0);
        check_eq("z_ready0", req0_ready, 1);
        tick();
        drive0(1'b0, 1'b0, 0);
        check_eq("z_done", done, 1);
        check_eq("z_busy", busy, 1);
        check_eq("z_count", count, 4);
        tick();
        check_eq("z_done_clr", done, 0);
        check_eq("z_busy_clr", busy, 0);
        check_eq("z_count_hold", count, 4);

        // Reset mid-RUN discards the command
        drive0(1'b1, 1'b1, 10);
        tick();
        drive0(1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) tick();
        check_eq("mid_count", count, 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_count", count, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check_eq("mid_no_done", seen_done, 0);
        drive1(1'b1, 1'b1, 1);
        check_eq("post_ready1", req1_ready, 1);
        tick();
        drive1(1'b0, 1'b0, 0);
        run_to_done(40, lat);
        check_eq("post_lat", lat, 1);
        check_eq("post_count", count, 1);
        check_eq("post_owner", owner, 1);
        tick();

        // Climb to 14, then overflow by three steps
        drive0(1'b1, 1'b1, 13);
        tick();
        drive0(1'b0, 1'b0, 0);
        run_to_done(40, lat);
        check_eq("c14_count", count, 14);
        check_eq("c14_sat", sat, 0);
        tick();
        drive0(1'b1, 1'b1, 3);
        check_eq("ovf_ready0", req0_ready, 1);
        tick();
        drive0(1'b0, 1'b0, 0);
        run_to_done(40, lat);
        check_eq("ovf_lat", lat, 3);
        check_eq("ovf_count", count, EXP_WRAP);
        check_eq("ovf_sat", sat, EXP_SAT);
        tick();
        check_eq("ovf_done_clr", done, 0);

        // Reset wins over a same-edge handshake
        rst = 1'b1;
        drive0(1'b1, 1'b1, 2);
        tick();
        rst = 1'b0;
        drive0(1'b0, 1'b0, 0);
        check_eq("prio_busy", busy, 0);
        check_eq("prio_count", count, 0);
        check_eq("prio_sat", sat, 0);
        tick();
        check_eq("prio_done", done, 0);
        check_eq("prio_busy2", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
